// File: rtl/fb_scanout_if.sv
// fb_scanout_if: framebuffer read port between the scan-out stage and its memory.
interface fb_scanout_if #(
    parameter int ADDRW = 16,
    parameter int COLRW = 12
);
    logic             fb_rd;
    logic [ADDRW-1:0] fb_addr;
    logic [COLRW-1:0] fb_data;
    modport master (output fb_rd, fb_addr, input fb_data);
    modport slave  (input fb_rd, fb_addr, output fb_data);
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: double line-buffered framebuffer scan-out with integer pixel scaling.
module fb_scanout #(
    parameter int CORDW = 16,
    parameter int FB_WIDTH = 320,
    parameter int FB_HEIGHT = 180,
    parameter int SCALE = 4,
    parameter int ADDRW = 16,
    parameter int COLRW = 12,
    parameter logic [COLRW-1:0] BG_COLR = '0
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix,
    input  logic                    frame,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    de_i,
    fb_scanout_if.master            fb,
    output logic [COLRW-1:0]        colr,
    output logic                    de_o,
    output logic                    busy,
    output logic                    err_overrun
);
    localparam int IW = FB_WIDTH > 1 ? $clog2(FB_WIDTH) : 1;
    localparam int SW = SCALE > 1 ? $clog2(SCALE) : 1;
    localparam logic signed [CORDW-1:0] ONE = 1;
    localparam logic signed [CORDW-1:0] LINES = CORDW'(FB_HEIGHT * SCALE);
    localparam logic signed [CORDW-1:0] PIX = CORDW'(FB_WIDTH * SCALE);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
    state_t state;

    logic signed [CORDW-1:0] t;
    logic                    fetch_req, vwrap, hwrap;
    logic [SW-1:0]           vsub, vsub_n, hsub, hsub_q;
    logic [ADDRW-1:0]        row_base, rb_n;
    logic [CORDW-1:0]        hcol, hcol_q;
    logic [IW-1:0]           rd_idx, col, wr_idx;
    logic                    wr_en, disp_sel, in_fb, de_d;
    logic [COLRW-1:0]        lb0 [FB_WIDTH];
    logic [COLRW-1:0]        lb1 [FB_WIDTH];
    logic [COLRW-1:0]        rd_data;

    // Row tracking targets the line after the current one (T = sy+1).
    always_comb begin
        t = sy + ONE;
        fetch_req = line && !t[CORDW-1] && t < LINES;
        vwrap = vsub == SW'(SCALE - 1);
        vsub_n = vsub;
        rb_n = row_base;
        if (frame || (fetch_req && t == '0)) begin
            vsub_n = '0;
            rb_n = '0;
        end else if (fetch_req) begin
            vsub_n = vwrap ? '0 : vsub + 1'b1;
            rb_n = vwrap ? row_base + ADDRW'(FB_WIDTH) : row_base;
        end
    end

    // Step counters replace a divide: hcol tracks floor(sx/SCALE).
    always_comb begin
        hwrap = hsub_q == SW'(SCALE - 1);
        hcol = sx == '0 ? '0 : hwrap ? hcol_q + 1'b1 : hcol_q;
        hsub = sx == '0 ? '0 : hwrap ? '0 : hsub_q + 1'b1;
        rd_idx = hcol < CORDW'(FB_WIDTH) ? hcol[IW-1:0] : '0;
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            state       <= IDLE;
            fb.fb_rd    <= 1'b0;
            fb.fb_addr  <= '0;
            busy        <= 1'b0;
            err_overrun <= 1'b0;
            col         <= '0;
            vsub        <= '0;
            row_base    <= '0;
            disp_sel    <= 1'b0;
            wr_en       <= 1'b0;
            wr_idx      <= '0;
            hcol_q      <= '0;
            hsub_q      <= '0;
            in_fb       <= 1'b0;
            de_d        <= 1'b0;
            colr        <= '0;
            de_o        <= 1'b0;
        end else begin
            vsub     <= vsub_n;
            row_base <= rb_n;
            hcol_q   <= hcol;
            hsub_q   <= hsub;
            // A line pulse drops the read still in flight from an abandoned fetch.
            wr_en    <= fb.fb_rd && !line;
            wr_idx   <= col;
            in_fb    <= de_i && !sx[CORDW-1] && sx < PIX && !sy[CORDW-1] && sy < LINES;
            de_d     <= de_i;
            colr     <= in_fb ? rd_data : de_d ? BG_COLR : '0;
            de_o     <= de_d;
            if (line) begin
                disp_sel <= !disp_sel;
                if (state != IDLE) err_overrun <= 1'b1;
                state    <= fetch_req ? FETCH : IDLE;
                fb.fb_rd <= fetch_req;
                busy     <= fetch_req;
                col      <= '0;
                if (fetch_req) fb.fb_addr <= rb_n;
            end else begin
                case (state)
                    FETCH: begin
                        if (col == IW'(FB_WIDTH - 1)) begin
                            fb.fb_rd <= 1'b0;
                            state    <= DRAIN;
                        end else begin
                            col        <= col + 1'b1;
                            fb.fb_addr <= fb.fb_addr + 1'b1;
                        end
                    end
                    DRAIN: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The back buffer is always the one not being displayed.
    always_ff @(posedge clk_pix) begin
        if (wr_en && disp_sel) lb0[wr_idx] <= fb.fb_data;
        if (wr_en && !disp_sel) lb1[wr_idx] <= fb.fb_data;
        rd_data <= disp_sel ? lb1[rd_idx] : lb0[rd_idx];
    end
endmodule
